// File: rtl/einstein_irq_pkg.sv
// einstein_irq_pkg: trigger modes, default vectors and FSM states shared by the interrupt controller
package einstein_irq_pkg;
    localparam logic [1:0] TRIG_LEVEL = 2'd0;
    localparam logic [1:0] TRIG_RISE  = 2'd1;
    localparam logic [1:0] TRIG_FALL  = 2'd2;
    localparam logic [1:0] TRIG_BOTH  = 2'd3;
    localparam logic [7:0] VEC_KB    = 8'h0E;
    localparam logic [7:0] VEC_FIRE  = 8'h0C;
    localparam logic [7:0] VEC_ADC   = 8'h0A;
    localparam logic [7:0] VEC_SPARE = 8'h08;
    typedef enum logic {ST_IDLE, ST_ACK} irq_state_e;
endpackage

// File: rtl/irq_trigger.sv
// irq_trigger: per-source sync flop, edge detect, mask flop and pending flop
module irq_trigger
    import einstein_irq_pkg::*;
#(
    parameter logic [1:0] MODE = TRIG_RISE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_src,
    input  logic i_mask_wr,
    input  logic i_mask_din,
    input  logic i_clr,
    input  logic i_ack,
    output logic o_pend
);
    logic r_src, r_mask, r_pend, w_edge, w_mask_nxt;

    // new mask takes effect in the same cycle it is written; edge selected by mode
    always_comb begin
        w_mask_nxt = i_mask_wr ? i_mask_din : r_mask;
        w_edge     = MODE == TRIG_RISE ? i_src & ~r_src :
                     MODE == TRIG_FALL ? ~i_src & r_src : i_src ^ r_src;
    end

    // masked edges are dropped; a fresh edge beats any clear in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src  <= 1'b0;
            r_mask <= 1'b1;
            r_pend <= 1'b0;
        end else begin
            r_src  <= i_src;
            r_mask <= w_mask_nxt;
            r_pend <= MODE == TRIG_LEVEL ? i_src & ~w_mask_nxt :
                      ~w_mask_nxt & (w_edge | (r_pend & ~i_clr & ~i_ack));
        end
    end

    assign o_pend = r_pend;
endmodule

// File: rtl/einstein_irq_ctrl.sv
// einstein_irq_ctrl: Mode-2 interrupt controller with CTC daisy-chain slot; EINSTEIN_IRQ_STATUS_EN adds a status port
module einstein_irq_ctrl
    import einstein_irq_pkg::*;
#(
    parameter int                       NUM_SRC   = 4,
    parameter logic [2*NUM_SRC-1:0]     TRIG      = {NUM_SRC{TRIG_RISE}},
    parameter logic [8*NUM_SRC-1:0]     VEC_TABLE = {VEC_SPARE, VEC_ADC, VEC_FIRE, VEC_KB},
    parameter int                       EXT_PRIO  = 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] mask_wr,
    input  logic               mask_din,
    input  logic [NUM_SRC-1:0] clr,
    input  logic               m1_n,
    input  logic               iorq_n,
    input  logic               reti,
    input  logic               ext_int_n,
    input  logic [7:0]         ext_vec,
    output logic               ext_iei,
    output logic               int_n,
    output logic [7:0]         vec,
    output logic               vec_oe
`ifdef EINSTEIN_IRQ_STATUS_EN
    ,
    input  logic               stat_rd,
    output logic [7:0]         stat_dout
`endif
);
    localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;

    irq_state_e         r_state, w_state_nxt;
    logic               r_inta, w_inta, w_inta_rise;
    logic [NUM_SRC-1:0] w_pend, r_isr, w_clr, w_ack, w_reti_clr, w_above;
    logic               w_hp_valid, w_hs_valid, w_ext_win, w_int_req, w_ext_iei;
    logic [IW-1:0]      w_hp_idx, w_hs_idx;
    logic [7:0]         w_hp_vec, w_vec_nxt, r_vec;
    logic               r_int_n;

    assign w_inta      = ~m1_n & ~iorq_n;
    assign w_inta_rise = w_inta & ~r_inta;

`ifdef EINSTEIN_IRQ_STATUS_EN
    logic [7:0] r_stat;
    logic [3:0] w_isr4, w_pend4;
    assign w_clr     = clr | {NUM_SRC{stat_rd}};
    assign stat_dout = r_stat;

    // status view is truncated or zero-extended to four sources
    always_comb begin
        w_isr4  = '0;
        w_pend4 = '0;
        for (int i = 0; i < NUM_SRC && i < 4; i++) begin
            w_isr4[i]  = r_isr[i];
            w_pend4[i] = w_pend[i];
        end
    end

    // status snapshot taken on the read strobe
    always_ff @(posedge clk_sys) begin
        if (reset) r_stat <= 8'h00;
        else if (stat_rd) r_stat <= {w_isr4, w_pend4};
    end
`else
    assign w_clr = clr;
`endif

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_trig
        irq_trigger #(.MODE(TRIG[2*g +: 2])) u_trig (
            .i_clk      (clk_sys),
            .i_rst      (reset),
            .i_src      (src_in[g]),
            .i_mask_wr  (mask_wr[g]),
            .i_mask_din (mask_din),
            .i_clr      (w_clr[g]),
            .i_ack      (w_ack[g]),
            .o_pend     (w_pend[g])
        );
    end

    // highest-priority pending and in-service sources; index 0 wins
    always_comb begin
        w_hp_valid = 1'b0;
        w_hp_idx   = '0;
        w_hp_vec   = 8'hFF;
        w_hs_valid = 1'b0;
        w_hs_idx   = '0;
        w_above    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_hp_valid = 1'b1;
                w_hp_idx   = IW'(i);
                w_hp_vec   = VEC_TABLE[8*i +: 8];
            end
            if (r_isr[i]) begin
                w_hs_valid = 1'b1;
                w_hs_idx   = IW'(i);
            end
            w_above[i] = i < EXT_PRIO;
        end
    end

    // request, daisy-chain gating, external arbitration and RETI clear
    always_comb begin
        w_int_req  = w_hp_valid & (~w_hs_valid | (w_hp_idx < w_hs_idx));
        w_ext_iei  = ~|((w_pend | r_isr) & w_above);
        w_ext_win  = ~ext_int_n & (~w_hp_valid | (int'(w_hp_idx) >= EXT_PRIO));
        w_reti_clr = '0;
        if (reti && r_state != ST_ACK && w_hs_valid) w_reti_clr[w_hs_idx] = 1'b1;
    end

    // acknowledge FSM: latch the winner on the INTA edge, hold the vector until INTA drops
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_ack       = '0;
        vec_oe      = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_inta_rise) begin
                w_state_nxt = ST_ACK;
                w_vec_nxt   = w_ext_win ? ext_vec : w_hp_vec;
                if (!w_ext_win && w_hp_valid) w_ack[w_hp_idx] = 1'b1;
            end
        end else begin
            vec_oe = w_inta;
            if (!w_inta) begin
                w_state_nxt = ST_IDLE;
                w_vec_nxt   = 8'hFF;
            end
        end
    end

    // FSM state, vector latch and INTA edge history
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_vec   <= 8'hFF;
            r_inta  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_inta  <= w_inta;
        end
    end

    // in-service tracking and registered CPU request
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_isr   <= '0;
            r_int_n <= 1'b1;
        end else begin
            r_isr   <= (r_isr | w_ack) & ~w_reti_clr;
            r_int_n <= ~(w_int_req | (~ext_int_n & w_ext_iei));
        end
    end

    assign int_n   = r_int_n;
    assign vec     = r_vec;
    assign ext_iei = w_ext_iei;
endmodule

// File: tb/tb_einstein_irq_ctrl.sv
// tb_einstein_irq_ctrl: directed checks of the interrupt controller (src1 both-edge, src3 level)
module tb_einstein_irq_ctrl;
    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] src_in = '0, mask_wr = '0, clr = '0;
    logic       mask_din = 1'b1, m1_n = 1'b1, iorq_n = 1'b1, reti = 1'b0, ext_int_n = 1'b1;
    logic [7:0] ext_vec = 8'h00;
    logic       ext_iei, int_n, vec_oe;
    logic [7:0] vec;
    int         n_chk = 0, n_pass = 0;

    einstein_irq_ctrl #(
        .NUM_SRC   (4),
        .TRIG      ({2'd0, 2'd1, 2'd3, 2'd1}),
        .VEC_TABLE ({8'h08, 8'h0A, 8'h0C, 8'h0E}),
        .EXT_PRIO  (1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .src_in    (src_in),
        .mask_wr   (mask_wr),
        .mask_din  (mask_din),
        .clr       (clr),
        .m1_n      (m1_n),
        .iorq_n    (iorq_n),
        .reti      (reti),
        .ext_int_n (ext_int_n),
        .ext_vec   (ext_vec),
        .ext_iei   (ext_iei),
        .int_n     (int_n),
        .vec       (vec),
        .vec_oe    (vec_oe)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic set_mask(input logic [3:0] sel, input logic val);
        mask_wr  = sel;
        mask_din = val;
        tick();
        mask_wr  = '0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic do_inta(input string tag, input logic [7:0] exp);
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        tick();
        chk({tag, "_oe"}, vec_oe, 1);
        chk({tag, "_vec"}, vec, exp);
        tick();
        chk({tag, "_hold"}, vec, exp);
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        #1;
        chk({tag, "_oe_off"}, vec_oe, 0);
        tick();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_int_n", int_n, 1);
        chk("rst_vec", vec, 8'hFF);
        chk("rst_vec_oe", vec_oe, 0);
        chk("rst_iei", ext_iei, 1);
        chk("rst_isr", dut.r_isr, 0);

        // basic: source 0 edge, two-cycle latency, acknowledge, RETI
        set_mask(4'b0001, 1'b0);
        src_in[0] = 1'b1;
        tick();
        chk("t1_pend", dut.w_pend, 4'b0001);
        chk("t1_int_n_early", int_n, 1);
        tick();
        chk("t1_int_n", int_n, 0);
        do_inta("t1", 8'h0E);
        chk("t1_int_n_after", int_n, 1);
        chk("t1_isr", dut.r_isr, 4'b0001);
        src_in[0] = 1'b0;
        pulse_reti();
        chk("t1_isr_clr", dut.r_isr, 0);

        // priority among 1 and 2, nesting by 0, RETI order
        set_mask(4'b0110, 1'b0);
        src_in[1] = 1'b1;
        src_in[2] = 1'b1;
        tick();
        chk("t2_pend", dut.w_pend, 4'b0110);
        tick();
        chk("t2_int_n", int_n, 0);
        do_inta("t2a", 8'h0C);
        chk("t2_held_off", int_n, 1);
        chk("t2_isr1", dut.r_isr, 4'b0010);
        src_in[0] = 1'b1;
        tick();
        tick();
        chk("t2_nested", int_n, 0);
        do_inta("t2b", 8'h0E);
        chk("t2_isr01", dut.r_isr, 4'b0011);
        pulse_reti();
        chk("t2_reti1", dut.r_isr, 4'b0010);
        pulse_reti();
        chk("t2_reti2", dut.r_isr, 4'b0000);
        src_in = '0;
        tick();
        clr = 4'b0110;
        tick();
        clr = '0;
        tick();
        tick();
        chk("t2_cleared", dut.w_pend, 0);
        chk("t2_idle_int_n", int_n, 1);

        // masked edges are discarded; mask write gates a same-cycle edge; masking clears pending
        set_mask(4'b0010, 1'b1);
        src_in[1] = 1'b1;
        tick();
        chk("t3_masked_edge", dut.w_pend, 0);
        set_mask(4'b0010, 1'b0);
        tick();
        chk("t3_unmask_int_n", int_n, 1);
        chk("t3_unmask_pend", dut.w_pend, 0);
        mask_wr = 4'b0010;
        mask_din = 1'b1;
        src_in[1] = 1'b0;
        tick();
        mask_wr = '0;
        chk("t3_same_cycle_mask", dut.w_pend, 0);
        set_mask(4'b0010, 1'b0);
        src_in[1] = 1'b1;
        tick();
        chk("t3_pend_set", dut.w_pend, 4'b0010);
        set_mask(4'b0010, 1'b1);
        chk("t3_mask_clears", dut.w_pend, 0);
        set_mask(4'b0010, 1'b0);
        tick();
        tick();

        // external slot above source 1, below source 0
        ext_vec = 8'h40;
        ext_int_n = 1'b0;
        src_in[1] = 1'b0;
        tick();
        tick();
        chk("t4_int_n", int_n, 0);
        chk("t4_iei_hi", ext_iei, 1);
        do_inta("t4_ext", 8'h40);
        chk("t4_pend1_kept", dut.w_pend, 4'b0010);
        chk("t4_isr_none", dut.r_isr, 0);
        ext_int_n = 1'b1;
        clr = 4'b0010;
        tick();
        clr = '0;
        ext_int_n = 1'b0;
        src_in[0] = 1'b1;
        tick();
        chk("t4_iei_lo_pend", ext_iei, 0);
        tick();
        do_inta("t4_int0", 8'h0E);
        chk("t4_iei_lo_isr", ext_iei, 0);
        pulse_reti();
        chk("t4_iei_back", ext_iei, 1);
        tick();
        chk("t4_ext_int_n", int_n, 0);
        ext_int_n = 1'b1;
        tick();
        tick();
        chk("t4_ext_gone", int_n, 1);

        // edge beats clr; reset during ACK
        src_in[2] = 1'b1;
        clr = 4'b0100;
        tick();
        clr = '0;
        chk("t5_edge_wins", dut.w_pend, 4'b0100);
        tick();
        m1_n = 1'b0;
        iorq_n = 1'b0;
        tick();
        chk("t5_ack_oe", vec_oe, 1);
        chk("t5_ack_vec", vec, 8'h0A);
        reset = 1'b1;
        tick();
        chk("t5_rst_oe", vec_oe, 0);
        chk("t5_rst_int_n", int_n, 1);
        chk("t5_rst_vec", vec, 8'hFF);
        chk("t5_rst_isr", dut.r_isr, 0);
        m1_n = 1'b1;
        iorq_n = 1'b1;
        reset = 1'b0;
        tick();

        // both-edge source 1
        set_mask(4'b0010, 1'b0);
        src_in[1] = 1'b1;
        tick();
        tick();
        chk("t6_rise_int_n", int_n, 0);
        do_inta("t6_rise", 8'h0C);
        pulse_reti();
        chk("t6_isr_clr", dut.r_isr, 0);
        src_in[1] = 1'b0;
        tick();
        tick();
        chk("t6_fall_int_n", int_n, 0);
        do_inta("t6_fall", 8'h0C);
        chk("t6_isr1", dut.r_isr, 4'b0010);
        pulse_reti();

        // level source 3: follows input, ignores clr
        mask_wr = 4'b1000;
        mask_din = 1'b0;
        src_in[3] = 1'b1;
        tick();
        mask_wr = '0;
        chk("t7_level_set", dut.w_pend[3], 1);
        clr = 4'b1000;
        tick();
        clr = '0;
        chk("t7_level_clr", dut.w_pend[3], 1);
        src_in[3] = 1'b0;
        tick();
        chk("t7_level_drop", dut.w_pend[3], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/einstein_irq_ctrl.md
Name: einstein_irq_ctrl

Overview:
- Parametrised Mode-2 interrupt controller for the Einstein core; replaces the fixed keyboard/CTC/fire vector mux and ad-hoc mask flops in the top level.
- Handles NUM_SRC internal sources, each with its own trigger mode, mask and vector, plus one external daisy-chain slot for the Z80 CTC.
- Drives the CPU INT_n, supplies the vector during INTA and tracks in-service state until RETI.
- Sits beside the I/O decoders; all inputs are synchronous to clk_sys (CPU strobes arrive already qualified by the CPU enable).

Parameters:
- NUM_SRC, 4: number of internal sources; index 0 has the highest priority.
- TRIG, {4{2'd1}}: 2 bits per source. 0 = level-high, 1 = rising edge, 2 = falling edge, 3 = both edges.
- VEC_TABLE, {8'h08,8'h0A,8'h0C,8'h0E}: 8-bit vector per source; source 0 is in the LSB byte.
- EXT_PRIO, 1: the external slot ranks immediately above internal source EXT_PRIO (0..NUM_SRC).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- src_in  in  NUM_SRC  raw request lines
- mask_wr  in  NUM_SRC  per-source mask write strobe, one cycle
- mask_din  in  1  new mask value; 1 = masked
- clr  in  NUM_SRC  per-source pending clear strobe (status-port read)
- m1_n  in  1  CPU M1
- iorq_n  in  1  CPU IORQ
- reti  in  1  one-cycle RETI pulse from the z80reti decoder
- ext_int_n  in  1  CTC INT_n
- ext_vec  in  8  CTC vector
- ext_iei  out  1  daisy-chain enable to the CTC IEI input
- int_n  out  1  CPU interrupt request, active-low
- vec  out  8  vector for the CPU data bus
- vec_oe  out  1  high while vec must drive the bus (INTA in progress)

Behaviour:
- Reset: all masks = 1; pending = 0; in-service = 0; int_n = 1; vec = 8'hFF; vec_oe = 0; ext_iei = 1; FSM in IDLE.
- Trigger stage:
  - One registered copy of src_in per source.
  - An edge is detected from the registered copy against the live src_in, according to TRIG.
- Pending, edge modes:
  - Set when an edge occurs and the source is unmasked.
  - Cleared by clr, or when that source wins INTA.
  - Edges on a masked source are discarded, not latched.
  - Edge and clr in the same cycle: edge wins.
  - Edge and mask_wr in the same cycle: the new mask value gates that edge.
- Pending, level mode: pending = src_in & ~mask, registered; clr has no effect.
- Masking a source that is already pending clears its pending bit on the next cycle.
- Latency: src_in edge at cycle t gives pending at t+1 and int_n low at t+2.
- int_n = 0 when the highest-priority pending internal source outranks every in-service source. Otherwise int_n follows ext_int_n, but only while ext_iei = 1. Registered.
- ext_iei = 0 whenever any internal source ranked above EXT_PRIO is pending or in service.
- inta = ~m1_n & ~iorq_n.
- FSM states:
  - IDLE: on the inta rising edge, latch the winner → ACK. The winner is the highest-priority pending internal source, or EXT if the external slot outranks it and ext_int_n = 0. If there is no winner, vec = 8'hFF and the FSM still goes to ACK.
  - ACK:
    - vec_oe = 1; vec holds the latched VEC_TABLE byte, or ext_vec sampled at the inta edge.
    - Stays stable while inta remains 1.
    - On the edge itself: the winner's pending bit clears and its in-service bit sets (EXT sets nothing internally).
    - On inta fall: vec_oe = 0 → IDLE.
- RETI: the reti pulse clears the highest-priority set in-service bit. It is ignored if in-service = 0 or if the FSM is in ACK.
- Nesting: a higher-priority source may assert int_n while a lower one is in service. Equal or lower priority sources are held off.
- reset asserted mid-ACK: immediate return to reset values; vec_oe drops in the same cycle reset is sampled.

Optional Feature:
- Macro: EINSTEIN_IRQ_STATUS_EN.
- When defined, adds two ports:
  - stat_rd  in  1
  - stat_dout  out  8
- stat_dout = {in_service[3:0], pending[3:0]} (zero-extended if NUM_SRC < 4), registered one cycle after stat_rd.
- A stat_rd also acts as clr for all edge-mode pending bits, except any bit that sets in the same cycle.
- Without the macro, neither port exists and clr is the only clear path.

Decomposition:
- Package einstein_irq_pkg holds:
  - trigger-mode constants TRIG_LEVEL, TRIG_RISE, TRIG_FALL, TRIG_BOTH;
  - vector constants VEC_KB = 8'h0E, VEC_FIRE = 8'h0C, VEC_ADC = 8'h0A, VEC_SPARE = 8'h08;
  - the FSM state enum.
- Sub-module irq_trigger: one per source, instantiated in a generate loop. Contains the sync flop, the edge detect, the mask flop and the pending flop.
- Priority and vector logic stay in the top module.

Test Plan:
- Reset, then mask_wr[0] with mask_din = 0, then rising edge on src_in[0] → int_n = 0 two cycles later. Assert inta → vec = 8'h0E with vec_oe = 1. After inta falls, int_n = 1 and in-service[0] = 1.
- Sources 1 and 2 unmasked and both pending; INTA → vec = 8'h0C. During service src_in[0] rises → int_n = 0 (nested). Two reti pulses → in-service[0] clears first, then in-service[1].
- Source 1 masked; its edge occurs; then unmask → int_n stays 1 and pending[1] = 0.
- ext_int_n = 0 with ext_vec = 8'h40 and EXT_PRIO = 1; source 1 pending → INTA returns 8'h40. With source 0 pending instead: ext_iei = 0 and INTA returns 8'h0E.
- Edge on src_in[2] in the same cycle as clr[2] → pending[2] = 1. reset asserted during ACK → vec_oe = 0 and int_n = 1 on the next cycle.
- TRIG = 3 on source 1: a 0→1 and a 1→0 toggle, each followed by an INTA → two interrupts, both vector 8'h0C.
